gpio_debouncer: RTL

Conditions the raw ZCU106 push-buttons (btnu/btnl/btnd/btnr/btnc) and DIP switches (sw[7:0]) before they enter the fpga core.
- Synchronises each input to clk, debounces it with a per-input stability counter, and emits clean levels.
- Generates one-cycle press/release/change pulses and a sticky, software-clearable button event register.
- Sits between the board top pins and the core's GPIO/status logic.

---
 rtl/gpio_pkg.sv | 14 +
 rtl/debounce_cell.sv | 53 +++++
 rtl/gpio_debouncer.sv | 81 ++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Board-level GPIO constants shared by the debouncer and its users.
// Button index names follow the ZCU106 push-button order u, l, d, r, c.
package gpio_pkg;
  localparam int N_BTN               = 5;
  localparam int N_SW                = 8;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 100000;

  localparam int BTN_U = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;
endpackage

// File: rtl/debounce_cell.sv
// Single-bit synchroniser and stability-counter debouncer with gated rise/fall pulses.
// Level follows a clean input SYNC_STAGES+DEBOUNCE_CYCLES edges later; no backpressure.
module debounce_cell
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic pulse_en,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Any sample that agrees with the accepted level restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_out == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= ~level;
        rise  <= pulse_en & ~level;
        fall  <= pulse_en & level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/gpio_debouncer.sv
// Debounces ZCU106 buttons and switches, adds start-up masking and a sticky press register.
// Levels lag clean inputs by SYNC_STAGES+DEBOUNCE_CYCLES edges; no backpressure.
module gpio_debouncer #(
  parameter int N_BTN           = gpio_pkg::N_BTN,
  parameter int N_SW            = gpio_pkg::N_SW,
  parameter int SYNC_STAGES     = gpio_pkg::SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = gpio_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_SW-1:0]  sw,
  input  logic [N_BTN-1:0] evt_clr,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_SW-1:0]  sw_change,
  output logic [N_BTN-1:0] evt_status,
  output logic             init_done
);
  import gpio_pkg::*;

  // Inputs already asserted at reset settle by edge ST_LAST, so events are
  // only unmasked once the edge after that has passed.
  localparam int ST_LAST = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int SCW     = $clog2(ST_LAST + 1);

  logic [SCW-1:0]  st_cnt;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_cnt    <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      if (st_cnt == SCW'(ST_LAST)) init_done <= 1'b1;
      else                         st_cnt    <= st_cnt + SCW'(1);
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .din     (btn[i]),
      .pulse_en(init_done),
      .level   (btn_level[i]),
      .rise    (btn_press[i]),
      .fall    (btn_release[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .din     (sw[i]),
      .pulse_en(init_done),
      .level   (sw_level[i]),
      .rise    (sw_rise[i]),
      .fall    (sw_fall[i])
    );
  end

  // Both terms are flops and can never be high together, so the OR is glitch-free.
  assign sw_change = sw_rise | sw_fall;

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) evt_status <= '0;
    else     evt_status <= (evt_status & ~evt_clr) | btn_press;
  end
endmodule
